// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator: forms aligned address, lane mask and
// shifted store data, waits MEM_LAT for read data, and extends load results.
// Optional misalignment trap is compiled in with `define LSU_MISALIGN_CHK_EN.
module lsu_mem_master #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    output logic [31:0] mem_raddr,
    output logic [31:0] mem_waddr,
    output logic        mem_r_en,
    output logic        mem_w_en,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t      state_reg;
    logic [1:0]  off_reg;
    logic [2:0]  funct3_reg;
    logic        load_reg;
    logic        misalign_reg;
    logic [2:0]  wait_cnt_reg;

    logic [1:0]  in_off;
    logic        op_store;
    logic        op_load;
    logic [7:0]  base_mask;
    logic [7:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic        misalign;

    assign in_off = in_addr[1:0];

    // Request-side decode; a store wins when both load and store are flagged.
    always_comb begin
        op_store = in_store;
        op_load  = in_load & ~in_store;
        case (in_funct3)
            3'b000:  base_mask = 8'h01;
            3'b001:  base_mask = 8'h03;
            3'b010:  base_mask = 8'h0F;
            default: base_mask = 8'h00;
        endcase
        lane_mask  = (base_mask << in_off) & 8'h0F;
        lane_wdata = in_wdata << {in_off, 3'b000};
`ifdef LSU_MISALIGN_CHK_EN
        misalign = (in_load | in_store) &
                   (((in_funct3[1:0] == 2'b01) & in_off[0]) |
                    ((in_funct3 == 3'b010) & (in_off != 2'b00)));
`else
        misalign = 1'b0;
`endif
    end

    logic [31:0] rd_shifted;
    logic [31:0] load_ext;

    always_comb begin
        rd_shifted = mem_rdata >> {off_reg, 3'b000};
        case (funct3_reg)
            3'b000:  load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b010:  load_ext = rd_shifted;
            3'b100:  load_ext = {24'd0, rd_shifted[7:0]};
            3'b101:  load_ext = {16'd0, rd_shifted[15:0]};
            default: load_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            in_ready     <= 1'b1;
            off_reg      <= 2'b00;
            funct3_reg   <= 3'b000;
            load_reg     <= 1'b0;
            misalign_reg <= 1'b0;
            wait_cnt_reg <= 3'd0;
            mem_raddr    <= 32'd0;
            mem_waddr    <= 32'd0;
            mem_r_en     <= 1'b0;
            mem_w_en     <= 1'b0;
            mem_wmask    <= 8'h00;
            mem_wdata    <= 32'd0;
            out_valid    <= 1'b0;
            out_rdata    <= 32'd0;
            out_err      <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        // Strobes are registered here so they appear exactly in the REQ cycle.
                        off_reg      <= in_off;
                        funct3_reg   <= in_funct3;
                        load_reg     <= op_load;
                        misalign_reg <= misalign;
                        mem_raddr    <= {in_addr[31:2], 2'b00};
                        mem_waddr    <= {in_addr[31:2], 2'b00};
                        mem_w_en     <= op_store & ~misalign;
                        mem_r_en     <= op_load & ~misalign;
                        mem_wmask    <= op_store ? lane_mask : 8'h00;
                        mem_wdata    <= op_store ? lane_wdata : 32'd0;
                        in_ready     <= 1'b0;
                        state_reg    <= S_REQ;
                    end
                end
                S_REQ: begin
                    mem_w_en <= 1'b0;
                    mem_r_en <= 1'b0;
                    if (load_reg && !misalign_reg) begin
                        wait_cnt_reg <= 3'(MEM_LAT - 1);
                        state_reg    <= S_WAIT;
                    end else begin
                        out_valid <= 1'b1;
                        out_err   <= misalign_reg;
                        out_rdata <= 32'd0;
                        state_reg <= S_RESP;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_reg == 3'd0) begin
                        out_rdata <= load_ext;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        state_reg <= S_RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 3'd1;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_err   <= 1'b0;
                        out_rdata <= 32'd0;
                        in_ready  <= 1'b1;
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Table-driven bench for lsu_mem_master with a result scoreboard and a
// latency-accurate read responder; hand-written reset-in-REQ sequence.
module tb_lsu_mem_master;

    localparam int MEM_LAT = 1;
    localparam int LD_LAT  = 2 + MEM_LAT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_load;
    logic        in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rdata;
    logic        out_err;

    always #5 clk = ~clk;

    lsu_mem_master #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_load(in_load), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err)
    );

    // Responder: read data is valid only MEM_LAT cycles after the strobe cycle.
    logic [7:0]  r_pipe = 8'h00;
    logic [31:0] resp_data = 32'd0;
    always @(posedge clk) r_pipe <= {r_pipe[6:0], mem_r_en};
    assign mem_rdata = r_pipe[MEM_LAT-1] ? resp_data : 32'h5A5A_5A5A;

    typedef struct {
        string       name;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          exp_w;
        int          exp_r;
        logic [31:0] exp_addr;
        logic [7:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_out;
        logic        exp_err;
        int          exp_lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic        err;
    } sb_t;

    vec_t tbl[$];
    sb_t  exp_q[$];
    int   checks = 0;
    int   failures = 0;

    function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
        end
    endfunction

    function automatic vec_t mk(string nm, logic ld, logic st, logic [2:0] f3,
                                logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata,
                                int ew, int er, logic [31:0] eaddr, logic [7:0] emask,
                                logic [31:0] ewdata, logic [31:0] eout, logic eerr,
                                int elat, int hold);
        vec_t v;
        v.name = nm; v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.exp_w = ew; v.exp_r = er;
        v.exp_addr = eaddr; v.exp_mask = emask; v.exp_wdata = ewdata;
        v.exp_out = eout; v.exp_err = eerr; v.exp_lat = elat; v.hold = hold;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        int          cyc;
        int          wcnt;
        int          rcnt;
        int          rdy_bad;
        logic [31:0] got_waddr;
        logic [31:0] got_raddr;
        logic [31:0] got_wdata;
        logic [7:0]  got_mask;
        logic [31:0] held;
        sb_t         e;
        wcnt = 0; rcnt = 0; rdy_bad = 0;
        got_waddr = 32'd0; got_raddr = 32'd0; got_wdata = 32'd0; got_mask = 8'h00;
        resp_data = v.rdata;
        @(negedge clk);
        chk({v.name, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_load = v.ld; in_store = v.st;
        in_funct3 = v.f3; in_addr = v.addr; in_wdata = v.wdata;
        exp_q.push_back('{v.exp_out, v.exp_err});
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (mem_w_en) begin
                wcnt++; got_waddr = mem_waddr; got_mask = mem_wmask; got_wdata = mem_wdata;
            end
            if (mem_r_en) begin
                rcnt++; got_raddr = mem_raddr;
            end
            if (in_ready) rdy_bad++;
            if (out_valid) break;
        end
        chk({v.name, " latency"}, 32'(cyc), 32'(v.exp_lat));
        chk({v.name, " w_strobes"}, 32'(wcnt), 32'(v.exp_w));
        chk({v.name, " r_strobes"}, 32'(rcnt), 32'(v.exp_r));
        chk({v.name, " in_ready_busy"}, 32'(rdy_bad), 32'd0);
        if (v.exp_w > 0) begin
            chk({v.name, " waddr"}, got_waddr, v.exp_addr);
            chk({v.name, " wmask"}, 32'(got_mask), 32'(v.exp_mask));
            chk({v.name, " wdata"}, got_wdata, v.exp_wdata);
        end
        if (v.exp_r > 0) chk({v.name, " raddr"}, got_raddr, v.exp_addr);
        e = exp_q.pop_front();
        if (out_valid) begin
            chk({v.name, " out_rdata"}, out_rdata, e.out);
            chk({v.name, " out_err"}, 32'(out_err), 32'(e.err));
        end
        held = out_rdata;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk({v.name, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({v.name, " hold_data"}, out_rdata, held);
            chk({v.name, " hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        $display("txn %-8s lat=%0d w=%0d r=%0d out_rdata=%08h out_err=%0d",
                 v.name, cyc, wcnt, rcnt, out_rdata, out_err);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({v.name, " done_valid"}, 32'(out_valid), 32'd0);
        chk({v.name, " done_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
        in_funct3 = 3'b000; in_addr = 32'd0; in_wdata = 32'd0; out_ready = 1'b0;

        tbl.push_back(mk("sw",     0, 1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 1, 0, 32'h8000_0004, 8'h0F, 32'hDEAD_BEEF, 32'h0, 0, 2, 0));
        tbl.push_back(mk("sb",     0, 1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 1, 0, 32'h8000_0000, 8'h08, 32'hA500_0000, 32'h0, 0, 2, 0));
        tbl.push_back(mk("lb",     1, 0, 3'b000, 32'h8000_0001, 32'h0, 32'h1234_F000, 0, 1, 32'h8000_0000, 8'h00, 32'h0, 32'hFFFF_FFF0, 0, LD_LAT, 0));
        tbl.push_back(mk("lbu",    1, 0, 3'b100, 32'h8000_0001, 32'h0, 32'h1234_F000, 0, 1, 32'h8000_0000, 8'h00, 32'h0, 32'h0000_00F0, 0, LD_LAT, 0));
        tbl.push_back(mk("lh_bp",  1, 0, 3'b001, 32'h8000_0002, 32'h0, 32'h8001_FFFF, 0, 1, 32'h8000_0000, 8'h00, 32'h0, 32'hFFFF_8001, 0, LD_LAT, 3));
        tbl.push_back(mk("lhu",    1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'h8001_FFFF, 0, 1, 32'h8000_0000, 8'h00, 32'h0, 32'h0000_8001, 0, LD_LAT, 0));
        tbl.push_back(mk("lw",     1, 0, 3'b010, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 0, 1, 32'h8000_0008, 8'h00, 32'h0, 32'hCAFE_F00D, 0, LD_LAT, 0));
        tbl.push_back(mk("sh",     0, 1, 3'b001, 32'h8000_0002, 32'h0000_1234, 32'h0, 1, 0, 32'h8000_0000, 8'h0C, 32'h1234_0000, 32'h0, 0, 2, 0));
        tbl.push_back(mk("sb_off1",0, 1, 3'b000, 32'h8000_0001, 32'h1234_5677, 32'h0, 1, 0, 32'h8000_0000, 8'h02, 32'h3456_7700, 32'h0, 0, 2, 0));
        tbl.push_back(mk("lb_pos", 1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h7F00_0000, 0, 1, 32'h8000_0000, 8'h00, 32'h0, 32'h0000_007F, 0, LD_LAT, 1));
        tbl.push_back(mk("ld_st",  1, 1, 3'b000, 32'h8000_0000, 32'h0000_0055, 32'h0, 1, 0, 32'h8000_0000, 8'h01, 32'h0000_0055, 32'h0, 0, 2, 0));
        tbl.push_back(mk("nop",    0, 0, 3'b010, 32'h8000_0010, 32'h1111_1111, 32'h0, 0, 0, 32'h0, 8'h00, 32'h0, 32'h0, 0, 2, 0));
        tbl.push_back(mk("s_rsv",  0, 1, 3'b011, 32'h8000_0000, 32'h0000_0001, 32'h0, 1, 0, 32'h8000_0000, 8'h00, 32'h0000_0001, 32'h0, 0, 2, 0));
        tbl.push_back(mk("l_rsv",  1, 0, 3'b110, 32'h8000_0004, 32'h0, 32'hFFFF_FFFF, 0, 1, 32'h8000_0004, 8'h00, 32'h0, 32'h0, 0, LD_LAT, 0));
`ifdef LSU_MISALIGN_CHK_EN
        tbl.push_back(mk("sw_mis", 0, 1, 3'b010, 32'h8000_0002, 32'h1122_3344, 32'h0, 0, 0, 32'h0, 8'h00, 32'h0, 32'h0, 1, 2, 0));
        tbl.push_back(mk("lw_mis", 1, 0, 3'b010, 32'h8000_0001, 32'h0, 32'hAABB_CCDD, 0, 0, 32'h0, 8'h00, 32'h0, 32'h0, 1, 2, 2));
        tbl.push_back(mk("lh_mis", 1, 0, 3'b001, 32'h8000_0001, 32'h0, 32'h1280_0034, 0, 0, 32'h0, 8'h00, 32'h0, 32'h0, 1, 2, 0));
`else
        tbl.push_back(mk("sw_mis", 0, 1, 3'b010, 32'h8000_0002, 32'h1122_3344, 32'h0, 1, 0, 32'h8000_0000, 8'h0C, 32'h3344_0000, 32'h0, 0, 2, 0));
        tbl.push_back(mk("lw_mis", 1, 0, 3'b010, 32'h8000_0001, 32'h0, 32'hAABB_CCDD, 0, 1, 32'h8000_0000, 8'h00, 32'h0, 32'h00AA_BBCC, 0, LD_LAT, 0));
        tbl.push_back(mk("lh_mis", 1, 0, 3'b001, 32'h8000_0001, 32'h0, 32'h1280_0034, 0, 1, 32'h8000_0000, 8'h00, 32'h0, 32'hFFFF_8000, 0, LD_LAT, 0));
`endif

        // Reset state, observed while reset is still asserted.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst mem_r_en", 32'(mem_r_en), 32'd0);
        chk("rst mem_w_en", 32'(mem_w_en), 32'd0);
        chk("rst mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst out_err", 32'(out_err), 32'd0);
        chk("rst out_rdata", out_rdata, 32'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Reset taken during the REQ cycle of a store.
        @(negedge clk);
        in_valid = 1'b1; in_store = 1'b1; in_funct3 = 3'b010;
        in_addr = 32'h8000_0004; in_wdata = 32'hFEED_FACE;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_store = 1'b0;
        @(negedge clk);
        chk("rstreq w_en_in_req", 32'(mem_w_en), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("rstreq w_en_after", 32'(mem_w_en), 32'd0);
        chk("rstreq in_ready", 32'(in_ready), 32'd1);
        chk("rstreq out_valid", 32'(out_valid), 32'd0);
        chk("rstreq wmask", 32'(mem_wmask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_w_en || mem_r_en || out_valid || !in_ready) bad++;
        end
        chk("rstreq quiet", 32'(bad), 32'd0);
        $display("txn rst_req  strobes_after_reset=%0d", bad);

        run_vec(tbl[0]);
        run_vec(tbl[2]);

        chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the execute stage and the data-SRAM responder.
- Accepts one memory op per handshake and forms the word-aligned address, byte mask and lane-shifted write data.
- Issues a single-cycle read or write strobe, waits the fixed responder read latency, then extracts and sign- or zero-extends load data.
- Returns the result to write-back over a valid/ready handshake. One op in flight at a time.

Parameters:
- MEM_LAT, 1, cycles from the mem_r_en cycle until mem_rdata is valid (responder registers rdata once); legal range 1..4.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_load  input  1  op is a load
- in_store  input  1  op is a store
- in_funct3  input  3  size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- in_addr  input  32  byte address
- in_wdata  input  32  store data, right-aligned
- mem_raddr  output  32  word-aligned read address
- mem_waddr  output  32  word-aligned write address
- mem_r_en  output  1  read strobe
- mem_w_en  output  1  write strobe
- mem_wmask  output  8  byte-lane mask; bits [7:4] always 0
- mem_wdata  output  32  lane-shifted write data
- mem_rdata  input  32  read data, valid MEM_LAT cycles after the mem_r_en cycle
- out_valid  output  1  result valid
- out_ready  input  1  write-back accepts result
- out_rdata  output  32  extended load data; 0 for stores
- out_err  output  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset (rst_n low at a posedge):
  - State goes to IDLE.
  - mem_r_en, mem_w_en, out_valid, out_err are 0; mem_wmask is 0; all address/data outputs are 0.
  - Applies from any state. A reset taken in REQ suppresses the strobe from the next cycle; no later access is issued for that op.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch addr, wdata, funct3, load, store, and offset off=in_addr[1:0]. Go to REQ.
- REQ (exactly 1 cycle):
  - mem_raddr = mem_waddr = {addr[31:2],2'b00}.
  - Store: mem_w_en=1; mem_wmask = (base<<off)&8'h0F, where base is 01 for b, 03 for h, 0F for w; mem_wdata = wdata<<(8*off). Next state RESP.
  - Load: mem_r_en=1. Next state WAIT.
  - Both in_load and in_store set: treated as store.
  - Neither set: no strobe. Go to RESP with out_rdata=0.
  - Reserved funct3 on a store: mask 0 but mem_w_en still 1.
- WAIT:
  - Lasts MEM_LAT cycles; strobes are 0.
  - On the last WAIT cycle, capture mem_rdata.
  - Extraction: s = rdata>>(8*off); lb sign-extends s[7:0]; lh sign-extends s[15:0]; lw takes s; lbu/lhu zero-extend. Reserved funct3 gives 0.
  - Next state RESP.
- RESP:
  - out_valid=1; out_rdata and out_err are held stable until out_ready.
  - On out_ready, go to IDLE. in_ready stays 0 in this cycle, so there is no back-to-back accept in the RESP handshake cycle.
- Strobes are 1 only in REQ, never for more than 1 cycle per op.
- Latency from accept cycle N:
  - Store: out_valid at N+2.
  - Load: out_valid at N+2+MEM_LAT.
- in_ready=0 in REQ, WAIT and RESP.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined:
  - In REQ, h/hu with off[0]=1, or w with off!=0, is misaligned.
  - A misaligned op drives no strobe, goes directly to RESP with out_err=1 and out_rdata=0. Store latency is unchanged (N+2); a misaligned load also completes at N+2.
- Undefined:
  - No check; out_err is tied 0.
  - Mask and shift are formed as above, so lanes beyond byte 3 are truncated.

Test Plan:
- Store sw, addr 0x80000004, wdata 0xDEADBEEF -> one REQ cycle with mem_w_en=1, waddr 0x80000004, wmask 0x0F, wdata 0xDEADBEEF; out_valid at N+2, out_rdata 0.
- Store sb, addr 0x80000003, wdata 0x000000A5 -> waddr 0x80000000, wmask 0x08, wdata 0xA5000000.
- Load lb, addr 0x80000001, mem_rdata 0x1234F000, MEM_LAT=1 -> mem_r_en for 1 cycle; out_rdata 0xFFFFFFF0 at N+3. Same with lbu -> 0x000000F0.
- Load lh, addr 0x80000002, mem_rdata 0x8001FFFF -> out_rdata 0xFFFF8001. With out_ready held 0 for 3 cycles, out_valid and data stay stable and in_ready=0 throughout.
- rst_n low during the REQ cycle of a store -> mem_w_en=0 from the next cycle, no further strobe, state IDLE, in_ready=1.
- With LSU_MISALIGN_CHK_EN defined, sw at 0x80000002 -> no mem_w_en, out_err=1 at N+2. Without the macro, wmask 0x0C and wdata shifted by 16.
